// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch and next-PC stage of the single-cycle RISC-V core.
// Holds the program counter, fetches one instruction word at a time from
// instruction memory over a ready handshake, presents it to the control
// decoder for one EXEC cycle, then selects the next PC from the decoder's
// branch/jump strobes and the ALU flags. Also counts retired instructions.
//
// Sequence per instruction: FETCH (1 + wait cycles) -> EXEC (1 cycle).
// One IDLE cycle follows reset before the first fetch.
//
// Parameters:
//   PC_WIDTH        width of PC, addresses, immediates and targets
//   RESET_PC        PC value loaded on reset
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   beq_in..bge_in  branch-type strobes from control
//   jal_in          instruction is jal
//   jalr_in         instruction is jalr
//   zero_in         ALU equal flag (rs1 == rs2)
//   lt_in           ALU signed less-than flag (rs1 < rs2)
//   imm_in          sign-extended B/J offset
//   jalr_target_in  ALU result rs1+imm for jalr
//   imem_req        fetch request (registered, high throughout FETCH)
//   imem_addr       fetch address, equal to pc_out
//   imem_ready      imem_rdata valid this cycle (looked at only in FETCH)
//   imem_rdata      fetched instruction word
//   instr_out       latched instruction word, feeds the decoder
//   instr_valid     high for exactly the one EXEC cycle of each instruction
//   pc_out          current PC
//   pc_plus4_out    pc_out + 4, link value for jal/jalr
//   instret_out     retired-instruction count (wraps)
//   trap_out        misaligned-target trap
//
// Configuration macro:
//   PC_MISALIGN_TRAP_EN  when defined, a next PC with bit 1 set enters the
//                        terminal TRAP state (pc keeps the faulting target).
//                        When undefined, next PC bits [1:0] are cleared,
//                        TRAP is unreachable and trap_out is tied low.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(32'h0040_0000)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                beq_in,
   input  logic                bne_in,
   input  logic                blt_in,
   input  logic                bge_in,
   input  logic                jal_in,
   input  logic                jalr_in,
   input  logic                zero_in,
   input  logic                lt_in,
   input  logic [PC_WIDTH-1:0] imm_in,
   input  logic [PC_WIDTH-1:0] jalr_target_in,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ready,
   input  logic [31:0]         imem_rdata,
   output logic [31:0]         instr_out,
   output logic                instr_valid,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic [PC_WIDTH-1:0] pc_plus4_out,
   output logic [31:0]         instret_out,
   output logic                trap_out
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_TRAP
   } state_t;

   state_t              state;
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] raw_next_pc;
   logic [PC_WIDTH-1:0] next_pc;
   logic                taken;

   assign pc_out       = pc_q;
   assign imem_addr    = pc_q;
   assign pc_plus4_out = pc_q + PC_WIDTH'(4);

   // Several strobes at once simply OR together; control never relies on it.
   assign taken = (beq_in &  zero_in) | (bne_in & ~zero_in) |
                  (blt_in &  lt_in)   | (bge_in & ~lt_in);

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      raw_next_pc = pc_plus4_out;
      if (jalr_in) begin
         raw_next_pc = {jalr_target_in[PC_WIDTH-1:1], 1'b0};
      end else if (jal_in || taken) begin
         raw_next_pc = pc_q + imm_in;
      end
   end

   // jalr always clears bit 0 of the target, so that bit is never consumed.
`ifdef PC_MISALIGN_TRAP_EN
   logic unused_target_lsb;
   assign unused_target_lsb = jalr_target_in[0];
   assign next_pc           = raw_next_pc;
`else
   logic unused_pc_bits;
   assign unused_pc_bits = ^{jalr_target_in[0], raw_next_pc[1:0]};
   assign next_pc        = {raw_next_pc[PC_WIDTH-1:2], 2'b00};
   assign trap_out       = 1'b0;
`endif

   // imem_req / instr_valid / trap_out are registered: they are set on the
   // edge that enters the state in which they must be high.
   // NOTE: all state here is sequential, so every assignment is non-blocking;
   // blocking assignments would make results depend on statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         pc_q        <= RESET_PC;
         instr_out   <= NOP_INSTR;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         instret_out <= '0;
`ifdef PC_MISALIGN_TRAP_EN
         trap_out    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
            end

            S_FETCH: begin
               if (imem_ready) begin
                  instr_out   <= imem_rdata;
                  state       <= S_EXEC;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
               end
            end

            S_EXEC: begin
               pc_q        <= next_pc;
               instret_out <= instret_out + 32'd1;
               instr_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
               if (next_pc[1]) begin
                  state    <= S_TRAP;
                  trap_out <= 1'b1;
               end else begin
                  state    <= S_FETCH;
                  imem_req <= 1'b1;
               end
`else
               state    <= S_FETCH;
               imem_req <= 1'b1;
`endif
            end

            S_TRAP: begin
               // Terminal until reset; everything holds.
               state <= S_TRAP;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Self-checking bench for pc_fetch_unit: a hand-computed table of branch/jump
// vectors, randomized instructions checked against a next-PC reference model,
// and hand-written sequences for wait states, misaligned targets and
// asynchronous reset during a fetch.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   typedef struct {
      logic        beq, bne, blt, bge, jal, jalr, zero, lt;
      logic [31:0] imm;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        beq_in, bne_in, blt_in, bge_in, jal_in, jalr_in, zero_in, lt_in;
   logic [31:0] imm_in, jalr_target_in;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic [31:0] pc_out, pc_plus4_out, instret_out;
   logic        trap_out;

   int checks   = 0;
   int failures = 0;

   // Reference state
   logic [31:0] m_pc;
   logic [31:0] m_count;
   logic [31:0] m_instr;

   vec_t vecs [16];

   pc_fetch_unit #(.PC_WIDTH(32), .RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .beq_in         (beq_in),
      .bne_in         (bne_in),
      .blt_in         (blt_in),
      .bge_in         (bge_in),
      .jal_in         (jal_in),
      .jalr_in        (jalr_in),
      .zero_in        (zero_in),
      .lt_in          (lt_in),
      .imm_in         (imm_in),
      .jalr_target_in (jalr_target_in),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .instr_out      (instr_out),
      .instr_valid    (instr_valid),
      .pc_out         (pc_out),
      .pc_plus4_out   (pc_plus4_out),
      .instret_out    (instret_out),
      .trap_out       (trap_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [7:0] f, input logic [31:0] imm,
                               input logic [31:0] tgt, input logic [31:0] exp_pc);
      vec_t v;
      {v.beq, v.bne, v.blt, v.bge, v.jal, v.jalr, v.zero, v.lt} = f;
      v.imm    = imm;
      v.tgt    = tgt;
      v.exp_pc = exp_pc;
      return v;
   endfunction

   // Next PC from the ISA rules, plain arithmetic.
   function automatic logic [31:0] model_next(input logic [31:0] pc, input vec_t v);
      logic        take;
      logic [31:0] t;
      take = (v.beq && v.zero) || (v.bne && !v.zero) || (v.blt && v.lt) || (v.bge && !v.lt);
      if (v.jalr)              t = v.tgt - (v.tgt % 2);
      else if (v.jal || take)  t = pc + v.imm;
      else                     t = pc + 32'd4;
`ifndef PC_MISALIGN_TRAP_EN
      t = t - (t % 4);
`endif
      return t;
   endfunction

   task automatic set_ctrl(input vec_t v);
      beq_in = v.beq; bne_in = v.bne; blt_in = v.blt; bge_in = v.bge;
      jal_in = v.jal; jalr_in = v.jalr; zero_in = v.zero; lt_in = v.lt;
      imm_in = v.imm; jalr_target_in = v.tgt;
   endtask

   // Garbage on the control inputs outside EXEC must have no effect.
   task automatic random_ctrl();
      {beq_in, bne_in, blt_in, bge_in, jal_in, jalr_in, zero_in, lt_in} = 8'($urandom);
      imm_in         = $urandom;
      jalr_target_in = $urandom;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_imem_req"},    imem_req,     32'd0);
      check({tag, "_instr_valid"}, instr_valid,  32'd0);
      check({tag, "_pc"},          pc_out,       RST_PC);
      check({tag, "_imem_addr"},   imem_addr,    RST_PC);
      check({tag, "_pc_plus4"},    pc_plus4_out, RST_PC + 32'd4);
      check({tag, "_instr"},       instr_out,    NOP);
      check({tag, "_instret"},     instret_out,  32'd0);
      check({tag, "_trap"},        trap_out,     32'd0);
   endtask

   // Runs one instruction starting in FETCH: `waits` not-ready cycles, then
   // the fetch, then EXEC with control vector v; exp_next is the required PC.
   task automatic run_instr(input int waits, input logic [31:0] word,
                            input vec_t v, input logic [31:0] exp_next);
      logic exp_trap;
      for (int i = 0; i < waits; i++) begin
         imem_ready = 1'b0;
         imem_rdata = $urandom;
         random_ctrl();
         check("wait_req",   imem_req,    32'd1);
         check("wait_addr",  imem_addr,   m_pc);
         check("wait_valid", instr_valid, 32'd0);
         check("wait_instr", instr_out,   m_instr);
         step();
      end
      check("fetch_req",  imem_req,  32'd1);
      check("fetch_addr", imem_addr, m_pc);
      imem_ready = 1'b1;
      imem_rdata = word;
      random_ctrl();
      step();
      // EXEC cycle
      imem_ready = 1'(($urandom));
      imem_rdata = $urandom;
      check("exec_valid",  instr_valid,  32'd1);
      check("exec_instr",  instr_out,    word);
      check("exec_req",    imem_req,     32'd0);
      check("exec_pc",     pc_out,       m_pc);
      check("exec_plus4",  pc_plus4_out, m_pc + 32'd4);
      set_ctrl(v);
      step();
      m_pc    = exp_next;
      m_count = m_count + 32'd1;
      m_instr = word;
`ifdef PC_MISALIGN_TRAP_EN
      exp_trap = exp_next[1];
`else
      exp_trap = 1'b0;
`endif
      check("next_pc",      pc_out,      m_pc);
      check("instret",      instret_out, m_count);
      check("after_valid",  instr_valid, 32'd0);
      check("after_trap",   trap_out,    32'(exp_trap));
      check("after_req",    imem_req,    32'(!exp_trap));
      random_ctrl();
   endtask

   initial begin
      vec_t v;
      int   waits;

      // Chained from pc=0x00400010; each expected PC worked out by hand.
      vecs[0]  = mk(8'b0100_0000, 32'hFFFF_FFF8, 32'h0,         32'h0040_0008); // bne taken -8
      vecs[1]  = mk(8'b0100_0010, 32'hFFFF_FFF8, 32'h0,         32'h0040_000C); // bne not taken
      vecs[2]  = mk(8'b1000_0010, 32'h0000_0010, 32'h0,         32'h0040_001C); // beq taken
      vecs[3]  = mk(8'b1000_0000, 32'h0000_0010, 32'h0,         32'h0040_0020); // beq not taken
      vecs[4]  = mk(8'b0010_0001, 32'h0000_0100, 32'h0,         32'h0040_0120); // blt taken
      vecs[5]  = mk(8'b0001_0001, 32'h0000_0100, 32'h0,         32'h0040_0124); // bge not taken
      vecs[6]  = mk(8'b0001_0000, 32'hFFFF_FFDC, 32'h0,         32'h0040_0100); // bge taken -0x24
      vecs[7]  = mk(8'b0000_0100, 32'h0000_0044, 32'h0040_0101, 32'h0040_0100); // jalr clears bit0
      vecs[8]  = mk(8'b0000_1000, 32'h0000_0040, 32'h0,         32'h0040_0140); // jal
      vecs[9]  = mk(8'b0000_1100, 32'h0000_0004, 32'h0050_0000, 32'h0050_0000); // jalr beats jal
      vecs[10] = mk(8'b0100_1000, 32'h0000_0008, 32'h0,         32'h0050_0008); // jal + bne
      vecs[11] = mk(8'b1100_0010, 32'h0000_0020, 32'h0,         32'h0050_0028); // beq|bne ORed
      vecs[12] = mk(8'b0010_0000, 32'h0000_0020, 32'h0,         32'h0050_002C); // blt not taken
      vecs[13] = mk(8'b0000_0100, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC); // jalr to top
      vecs[14] = mk(8'b0000_0000, 32'h0000_0000, 32'h0,         32'h0000_0000); // pc+4 wraps
      vecs[15] = mk(8'b0010_0101, 32'h0000_0008, 32'h0040_0000, 32'h0040_0000); // jalr beats blt

      reset      = 1'b1;
      imem_ready = 1'b0;
      imem_rdata = '0;
      random_ctrl();
      m_pc    = RST_PC;
      m_count = '0;
      m_instr = NOP;

      // ---- Reset and IDLE cycle ------------------------------------------
      step();
      step();
      check_reset_vals("reset");
      imem_ready = 1'b1;  // ignored outside FETCH
      reset = 1'b0;
      check("idle_req", imem_req, 32'd0);
      step();
      check("first_req", imem_req, 32'd1);

      // ---- Sequential nops, zero-wait -----------------------------------
      v = mk(8'b0, 32'h0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) run_instr(0, NOP, v, m_pc + 32'd4);
      check("seq_pc",      pc_out,      32'h0040_000C);
      check("seq_instret", instret_out, 32'd3);

      // ---- Three wait states: 5-cycle instruction ------------------------
      run_instr(3, 32'h0010_0093, v, 32'h0040_0010);

      // ---- Hand-computed branch/jump table --------------------------------
      for (int i = 0; i < 16; i++) begin
         run_instr(i % 3, $urandom, vecs[i], vecs[i].exp_pc);
      end

      // ---- Randomized instructions against the model ---------------------
      for (int i = 0; i < 60; i++) begin
         v = mk(8'($urandom), 32'((int'($urandom_range(0, 64)) - 32) * 4),
                $urandom & 32'hFFFF_FFFD, 32'h0);
         waits = int'($urandom_range(0, 2));
         run_instr(waits, $urandom, v, model_next(m_pc, v));
      end

      // ---- Misaligned jal target ----------------------------------------
      v = mk(8'b0000_1000, 32'h0000_0002, 32'h0, 32'h0);
      run_instr(0, 32'h0020_006F, v, model_next(m_pc, v));
`ifdef PC_MISALIGN_TRAP_EN
      for (int i = 0; i < 4; i++) begin
         imem_ready = 1'b1;
         check("trap_hold_req",   imem_req,    32'd0);
         check("trap_hold_flag",  trap_out,    32'd1);
         check("trap_hold_valid", instr_valid, 32'd0);
         check("trap_hold_pc",    pc_out,      m_pc);
         step();
      end
`else
      run_instr(1, NOP, mk(8'b0, 32'h0, 32'h0, 32'h0), m_pc + 32'd4);
`endif

      // ---- Asynchronous reset in the middle of a fetch -------------------
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      #2;
      reset = 1'b1;
      #1;
      check_reset_vals("async_rst");
      step();
      check_reset_vals("rst_held");
      reset   = 1'b0;
      m_pc    = RST_PC;
      m_count = '0;
      m_instr = NOP;
      check("restart_idle", imem_req, 32'd0);
      step();
      run_instr(0, NOP, mk(8'b0, 32'h0, 32'h0, 32'h0), RST_PC + 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
